// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encodings, opcode constants and stack depth for
//               the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int C_STACK_DEPTH = 4;

    // The low two bits are what the State port shows; HALT reads back as 00.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] C_OP_JMP  = 4'hA;
    localparam logic [3:0] C_OP_JC   = 4'hB;
    localparam logic [3:0] C_OP_CALL = 4'hC;
    localparam logic [3:0] C_OP_RET  = 4'hD;
    localparam logic [3:0] C_OP_HLT  = 4'hF;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

    function automatic logic is_nop(input logic [3:0] op);
        return !is_alu(op) && (op != C_OP_JMP) && (op != C_OP_JC) &&
               (op != C_OP_CALL) && (op != C_OP_RET) && (op != C_OP_HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Instruction/datapath side signals of the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic [3:0] Opcode;
    logic       Cond_Met;
    logic [7:0] PC;
    logic       Ld_IR;
    logic       Incrmnt_PC;
    logic       Ld_Brnch_Addr;
    logic       Ld_Rtn_Addr;
    logic [7:0] Return_Addr;
    logic       Reg_Wr_En;
    logic       Halted;
    logic       Stk_Err;
    logic [1:0] State;

    modport master (
        input  Opcode, Cond_Met, PC,
        output Ld_IR, Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Return_Addr,
               Reg_Wr_En, Halted, Stk_Err, State
    );

    modport slave (
        output Opcode, Cond_Met, PC,
        input  Ld_IR, Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Return_Addr,
               Reg_Wr_En, Halted, Stk_Err, State
    );
endinterface
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Circular return-address stack; a push when full overwrites
//               the oldest entry, dout shows the current top entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = C_STACK_DEPTH
)
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       push,
    input  wire logic       pop,
    input  wire logic [7:0] din,
    output logic [7:0]      dout,
    output logic            full,
    output logic            empty
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_sp;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] w_top_idx;

    assign w_top_idx = r_sp - 1'b1;
    assign dout      = r_mem[w_top_idx];
    assign full      = (r_cnt == C_FULL);
    assign empty     = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (push) begin
            r_mem[r_sp] <= din;
            r_sp        <= r_sp + 1'b1;
            if (!full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (pop && !empty) begin
            r_sp  <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Four-phase fetch/decode/execute/writeback sequencer with a
//               return-address stack. Define STK_TRAP_EN to halt on stack
//               overflow/underflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int STACK_DEPTH = C_STACK_DEPTH
)
(
    input  wire logic       Clk,
    input  wire logic       Reset,
    pc_sequencer_if.master  bus
);

    state_t     r_state;
    state_t     w_next_state;

    logic [3:0] r_op;
    logic [7:0] r_ret;
    logic       r_incr;
    logic       r_brnch;
    logic       r_rtn;
    logic       r_wr;
    logic       r_halt_pend;

    logic       w_is_call;
    logic       w_is_ret;
    logic       w_is_jc;
    logic       w_fault;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_stk_dout;
    logic       w_stk_full;
    logic       w_stk_empty;

    assign w_is_call = (r_op == C_OP_CALL);
    assign w_is_ret  = (r_op == C_OP_RET);
    assign w_is_jc   = (r_op == C_OP_JC);

`ifdef STK_TRAP_EN
    logic r_err;

    assign w_fault     = (w_is_call && w_stk_full) || (w_is_ret && w_stk_empty);
    assign bus.Stk_Err = r_err;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_EXECUTE) && w_fault) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_full;

    assign w_unused_full = w_stk_full;
    assign w_fault       = 1'b0;
    assign bus.Stk_Err   = 1'b0;
`endif

    assign w_push = (r_state == ST_EXECUTE) && w_is_call && !w_fault;
    assign w_pop  = (r_state == ST_EXECUTE) && w_is_ret  && !w_fault;

    ret_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (Clk),
        .rst   (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.PC + 8'd1),
        .dout  (w_stk_dout),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:     w_next_state = ST_DECODE;
            ST_DECODE:    w_next_state = ST_EXECUTE;
            ST_EXECUTE:   w_next_state = ST_WRITEBACK;
            ST_WRITEBACK: w_next_state = r_halt_pend ? ST_HALT : ST_FETCH;
            ST_HALT:      w_next_state = ST_HALT;
            default:      w_next_state = ST_FETCH;
        endcase
    end

    // Writeback strobes are resolved at the end of EXECUTE so every output is a flop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_op        <= 4'h0;
            r_ret       <= 8'h00;
            r_incr      <= 1'b0;
            r_brnch     <= 1'b0;
            r_rtn       <= 1'b0;
            r_wr        <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_incr  <= 1'b0;
            r_brnch <= 1'b0;
            r_rtn   <= 1'b0;
            r_wr    <= 1'b0;
            if (r_state == ST_DECODE) begin
                r_op <= bus.Opcode;
            end
            if (r_state == ST_EXECUTE) begin
                r_incr      <= !w_fault && (is_alu(r_op) || is_nop(r_op) ||
                                            (w_is_jc && !bus.Cond_Met));
                r_brnch     <= !w_fault && ((r_op == C_OP_JMP) || w_is_call ||
                                            (w_is_jc && bus.Cond_Met));
                r_rtn       <= !w_fault && w_is_ret;
                r_wr        <= is_alu(r_op);
                r_halt_pend <= (r_op == C_OP_HLT) || w_fault;
            end
            if (w_pop) begin
                r_ret <= w_stk_empty ? 8'h00 : w_stk_dout;
            end
        end
    end

    assign bus.Ld_IR         = (r_state == ST_FETCH);
    assign bus.State         = r_state[1:0];
    assign bus.Halted        = (r_state == ST_HALT);
    assign bus.Incrmnt_PC    = r_incr;
    assign bus.Ld_Brnch_Addr = r_brnch;
    assign bus.Ld_Rtn_Addr   = r_rtn;
    assign bus.Reg_Wr_En     = r_wr;
    assign bus.Return_Addr   = r_ret;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench: queue-based instruction model, per-cycle
//               compare, directed scenarios and randomized instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit trap_mode;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: phase counter, halt flag, LIFO queue.
    int         m_phase;
    bit         m_halted;
    logic [3:0] m_op;
    logic [7:0] m_ret;
    bit         m_err;
    bit         m_incr, m_br, m_rtn, m_wr, m_fault;
    bit         m_call, m_retop;
    logic [7:0] m_nxt;
    logic [7:0] stk[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_halted = 0; m_op = 0; m_ret = 0; m_err = 0;
            m_incr = 0; m_br = 0; m_rtn = 0; m_wr = 0; m_fault = 0;
            stk.delete();
        end else if (!m_halted) begin
            case (m_phase)
                0: m_phase = 1;
                1: begin m_op = bus.Opcode; m_phase = 2; end
                2: begin
                    m_call  = (m_op == 4'hC);
                    m_retop = (m_op == 4'hD);
                    m_fault = trap_mode && ((m_call && stk.size() == DEPTH) ||
                                            (m_retop && stk.size() == 0));
                    if (m_fault) begin
                        m_err = 1;
                    end else if (m_call) begin
                        m_nxt = bus.PC + 8'd1;
                        stk.push_back(m_nxt);
                        if (stk.size() > DEPTH) void'(stk.pop_front());
                    end else if (m_retop) begin
                        m_ret = (stk.size() == 0) ? 8'h00 : stk.pop_back();
                    end
                    m_wr   = (m_op >= 4'h1) && (m_op <= 4'h7);
                    m_br   = !m_fault && (m_op == 4'hA || m_call || (m_op == 4'hB && bus.Cond_Met));
                    m_rtn  = !m_fault && m_retop;
                    m_incr = !m_fault && !m_br && !m_retop && (m_op != 4'hF);
                    m_phase = 3;
                end
                default: begin
                    if (m_op == 4'hF || m_fault) m_halted = 1;
                    m_phase = 0;
                end
            endcase
        end
    end

    bit wb;
    always @(negedge clk) begin
        if (cmp_en) begin
            wb = (m_phase == 3) && !m_halted;
            chk("state",  32'(bus.State), m_halted ? 32'd0 : 32'(m_phase));
            chk("ld_ir",  32'(bus.Ld_IR), 32'(!m_halted && m_phase == 0));
            chk("incr",   32'(bus.Incrmnt_PC), 32'(wb && m_incr));
            chk("brnch",  32'(bus.Ld_Brnch_Addr), 32'(wb && m_br));
            chk("rtn",    32'(bus.Ld_Rtn_Addr), 32'(wb && m_rtn));
            chk("wr",     32'(bus.Reg_Wr_En), 32'(wb && m_wr));
            chk("retadr", 32'(bus.Return_Addr), 32'(m_ret));
            chk("halted", 32'(bus.Halted), 32'(m_halted));
            chk("stkerr", 32'(bus.Stk_Err), 32'(m_err));
        end
    end

    logic [3:0] c_ldir, c_incr, c_br, c_rtn, c_wr;
    logic [1:0] c_state [4];
    logic [7:0] c_ret;

    // Called at posedge+3 with the DUT in FETCH; returns at posedge+3 one instruction later.
    task automatic instr(input logic [3:0] op, input logic cond, input logic [7:0] pc);
        bus.Opcode = op; bus.Cond_Met = cond; bus.PC = pc;
        for (int i = 0; i < 4; i++) begin
            #1;
            c_ldir[i]  = bus.Ld_IR;
            c_incr[i]  = bus.Incrmnt_PC;
            c_br[i]    = bus.Ld_Brnch_Addr;
            c_rtn[i]   = bus.Ld_Rtn_Addr;
            c_wr[i]    = bus.Reg_Wr_En;
            c_state[i] = bus.State;
            if (i == 3) c_ret = bus.Return_Addr;
            @(posedge clk); #3;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    logic [3:0] r_op;
    logic [7:0] exp_lifo [4];

    initial begin
        bus.Opcode = 4'h0; bus.Cond_Met = 1'b0; bus.PC = 8'h00;
`ifdef STK_TRAP_EN
        trap_mode = 1'b1;
`else
        trap_mode = 1'b0;
`endif
        #1 rst = 1'b1;
        @(posedge clk); #3;
        cmp_en = 1'b1;
        chk("rst_state",  32'(bus.State), 32'd0);
        chk("rst_ldir",   32'(bus.Ld_IR), 32'd1);
        chk("rst_strobes", 32'({bus.Incrmnt_PC, bus.Ld_Brnch_Addr, bus.Ld_Rtn_Addr, bus.Reg_Wr_En}), 32'd0);
        chk("rst_status", 32'({bus.Halted, bus.Stk_Err}), 32'd0);
        chk("rst_ret",    32'(bus.Return_Addr), 32'h00);
        @(posedge clk); #3;
        rst = 1'b0;

        instr(4'h1, 1'b0, 8'h05);
        chk("alu_c0_ldir", 32'(c_ldir[0]), 32'd1);
        chk("alu_c3_wr",   32'(c_wr[3]), 32'd1);
        chk("alu_c3_incr", 32'(c_incr[3]), 32'd1);
        chk("alu_c3_st",   32'(c_state[3]), 32'd3);
        chk("alu_c4_st",   32'(bus.State), 32'd0);

        instr(4'hB, 1'b0, 8'h06);
        chk("jc0_strobes", 32'({c_incr[3], c_br[3]}), 32'b10);
        instr(4'hB, 1'b1, 8'h07);
        chk("jc1_strobes", 32'({c_incr[3], c_br[3]}), 32'b01);

        instr(4'hC, 1'b0, 8'h10);
        instr(4'hD, 1'b0, 8'h33);
        chk("ret_addr_11", 32'(c_ret), 32'h11);
        chk("ret_rtn_wb",  32'(c_rtn[3]), 32'd1);
        instr(4'hC, 1'b0, 8'hFF);
        instr(4'hD, 1'b0, 8'h34);
        chk("ret_addr_wrap", 32'(c_ret), 32'h00);

        do_reset();
        for (int i = 0; i < 5; i++) instr(4'hC, 1'b0, 8'(8'h20 + i));
        if (trap_mode) begin
            chk("ovf_stkerr", 32'(bus.Stk_Err), 32'd1);
            chk("ovf_halted", 32'(bus.Halted), 32'd1);
        end else begin
            exp_lifo = '{8'h25, 8'h24, 8'h23, 8'h22};
            for (int i = 0; i < 4; i++) begin
                instr(4'hD, 1'b0, 8'h00);
                chk("lifo_ret", 32'(c_ret), 32'(exp_lifo[i]));
            end
        end

        do_reset();
        instr(4'hF, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            chk("hlt_halted", 32'(bus.Halted), 32'd1);
            chk("hlt_strobes", 32'({bus.Ld_IR, bus.Incrmnt_PC, bus.Ld_Brnch_Addr,
                                    bus.Ld_Rtn_Addr, bus.Reg_Wr_En}), 32'd0);
            @(posedge clk); #3;
        end

        do_reset();
        instr(4'hC, 1'b0, 8'h40);
        bus.Opcode = 4'hC; bus.PC = 8'h50;
        @(posedge clk); #3;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rstexec_state", 32'(bus.State), 32'd0);
        chk("rstexec_ldir",  32'(bus.Ld_IR), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        instr(4'hD, 1'b0, 8'h00);
        if (trap_mode) begin
            chk("rstexec_empty_err", 32'(bus.Stk_Err), 32'd1);
        end else begin
            chk("rstexec_empty_ret", 32'(c_ret), 32'h00);
            chk("rstexec_empty_rtn", 32'(c_rtn[3]), 32'd1);
        end

        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       r_op = 4'hC;
                1:       r_op = 4'hD;
                default: r_op = 4'($urandom_range(0, 14));
            endcase
            if ($urandom_range(0, 99) == 0) r_op = 4'hF;
            instr(r_op, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if (m_halted) begin
                @(posedge clk); #3;
                do_reset();
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, giving the number of return-address stack entries (power of 2, 2..16).
REQ-002 SHALL have port Clk, input, 1, CPU clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port Opcode, input, 4, opcode field from the instruction register; sampled in DECODE.
REQ-005 SHALL have port Cond_Met, input, 1, ALU condition flag; sampled in EXECUTE.
REQ-006 SHALL have port PC, input, 8, current program counter value.
REQ-007 SHALL have port Ld_IR, output, 1, load instruction register (FETCH).
REQ-008 SHALL have ports Incrmnt_PC, Ld_Brnch_Addr and Ld_Rtn_Addr, outputs, 1 each, PC controls (WRITEBACK only).
REQ-009 SHALL have port Return_Addr, output, 8, popped return address.
REQ-010 SHALL have port Reg_Wr_En, output, 1, register-file write strobe.
REQ-011 SHALL have ports Halted and Stk_Err, outputs, 1 each, status; port State, output, 2, current cycle state.

Function
REQ-012 SHALL cycle FETCH(00) -> DECODE(01) -> EXECUTE(10) -> WRITEBACK(11) -> FETCH, one clock per state.
REQ-013 SHALL assert Ld_IR only while State=FETCH.
REQ-014 SHALL decode opcodes: 1-7 ALU, A JMP, B JC, C CALL, D RET, F HLT, all others NOP.
REQ-015 SHALL, in WRITEBACK, assert exactly one of Incrmnt_PC, Ld_Brnch_Addr or Ld_Rtn_Addr, or none for HLT.
REQ-016 SHALL assert Ld_Brnch_Addr for JMP, for CALL, and for JC when Cond_Met was 1 in EXECUTE.
REQ-017 SHALL assert Incrmnt_PC for ALU, NOP, and JC not taken.
REQ-018 SHALL assert Reg_Wr_En only in WRITEBACK, and only for ALU opcodes.
REQ-019 SHALL, for CALL, push PC+1 (mod 256; 0xFF wraps to 0x00) in EXECUTE.
REQ-020 SHALL, for RET, pop in EXECUTE, register the value on Return_Addr, hold it until the next pop, and assert Ld_Rtn_Addr in WRITEBACK.
REQ-021 SHALL, for HLT, enter HALT after WRITEBACK, set Halted=1, drive all strobes to 0, and leave HALT only on Reset.
REQ-022 SHALL keep an occupancy count in the range 0..STACK_DEPTH; a push and a pop never occur in the same cycle.
REQ-023 SHALL keep all outputs registered or decoded from State only, with no combinational path from Opcode to the strobes.

Reset
REQ-024 SHALL, on Reset=1 at any time including mid-instruction, force State=FETCH, stack count=0, Return_Addr=0x00, Halted=0 and Stk_Err=0.
REQ-025 SHALL drive all strobes to 0 while Reset=1, except Ld_IR, which is 1 because State=FETCH.
REQ-026 SHALL resume at FETCH on the first rising edge after Reset deasserts.

Configuration
REQ-027 SHALL, with STK_TRAP_EN defined, treat CALL on a full stack or RET on an empty stack as a fault: set Stk_Err=1 sticky, perform no push/pop, issue no PC strobe, and enter HALT.
REQ-028 SHALL, without STK_TRAP_EN, let overflow overwrite the oldest entry (circular pointer) and let underflow return 0x00 with the count held at 0; Stk_Err is then constant 0.

Structure
REQ-029 SHALL define the state encodings, opcode constants and the default STACK_DEPTH in a shared package pc_seq_pkg.
REQ-030 SHALL implement the return-address stack as sub-module ret_stack (push, pop, din, dout, full, empty).

Verification
REQ-031 SHALL verify: Reset, then Opcode=1 -> Ld_IR at cycle 0, Reg_Wr_En and Incrmnt_PC at cycle 3, back to FETCH at cycle 4.
REQ-032 SHALL verify: JC with Cond_Met=0 -> Incrmnt_PC; JC with Cond_Met=1 -> Ld_Brnch_Addr, never both.
REQ-033 SHALL verify: CALL at PC=0x10, then RET -> Return_Addr=0x11 with Ld_Rtn_Addr in WRITEBACK; CALL at PC=0xFF -> Return_Addr=0x00.
REQ-034 SHALL verify: 5 CALLs at depth 4 -> Stk_Err=1 and Halted=1 with STK_TRAP_EN; with the macro undefined, 4 RETs return the last 4 pushed values in LIFO order.
REQ-035 SHALL verify: HLT -> Halted=1 and no strobes for 20 cycles; Reset asserted in EXECUTE of a CALL -> stack empty, State=FETCH.
